// File: rtl/pc_sequencer.sv
// Y86-style program-counter sequencer: retires completed instructions, picks the next PC,
// and tracks RUN/HALT/FAULT status with saturating retired/taken counters.
module pc_sequencer #(
   parameter int                ADDR_W    = 64,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(2**16),
   parameter int                CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              upd_valid,
   input  logic              stall,
   input  logic [3:0]        icode,
   input  logic              Cnd,
   input  logic [ADDR_W-1:0] valC,
   input  logic [ADDR_W-1:0] valM,
   input  logic [ADDR_W-1:0] valP,
   input  logic              exc_adr,
   input  logic              exc_ins,
   input  logic              go,
   input  logic [ADDR_W-1:0] go_pc,
   output logic [ADDR_W-1:0] PC,
   output logic [2:0]        stat,
   output logic [CNT_W-1:0]  retired,
   output logic [CNT_W-1:0]  taken
);

   typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [2:0]        stat_q, stat_d;
   logic [CNT_W-1:0]  retired_q, retired_d;
   logic [CNT_W-1:0]  taken_q, taken_d;
   logic [ADDR_W-1:0] target;
   logic              accept;
   logic              retire_inc;
   logic              taken_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         stat_q    <= STAT_AOK;
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         stat_q    <= stat_d;
         retired_q <= retired_d;
         taken_q   <= taken_d;
      end
   end

   always_comb begin
      target = valP;
      case (icode)
         4'h7:    target = Cnd ? valC : valP;
         4'h8:    target = valC;
         4'h9:    target = valM;
         default: target = valP;
      endcase
   end

   // Exceptions and out-of-range targets leave PC and counters untouched.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      stat_d     = stat_q;
      retire_inc = 1'b0;
      taken_inc  = 1'b0;
      accept     = upd_valid && !stall;
      case (state_q)
         RUN: begin
            if (accept) begin
               if (exc_adr) begin
                  stat_d  = STAT_ADR;
                  state_d = FAULT;
               end else if (exc_ins) begin
                  stat_d  = STAT_INS;
                  state_d = FAULT;
               end else if (icode == 4'h0) begin
                  stat_d     = STAT_HLT;
                  state_d    = HALT;
                  retire_inc = 1'b1;
               end else if (target >= MEM_LIMIT) begin
                  stat_d  = STAT_ADR;
                  state_d = FAULT;
               end else begin
                  pc_d       = target;
                  retire_inc = 1'b1;
                  taken_inc  = (icode == 4'h7) && Cnd;
               end
            end
         end
         HALT: begin
            if (go) begin
               if (go_pc >= MEM_LIMIT) begin
                  stat_d  = STAT_ADR;
                  state_d = FAULT;
               end else begin
                  pc_d    = go_pc;
                  stat_d  = STAT_AOK;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = FAULT;
         end
      endcase
      retired_d = (retire_inc && !(&retired_q)) ? retired_q + CNT_W'(1) : retired_q;
      taken_d   = (taken_inc && !(&taken_q)) ? taken_q + CNT_W'(1) : taken_q;
   end

   always_comb begin
      PC      = pc_q;
      stat    = stat_q;
      retired = retired_q;
      taken   = taken_q;
   end

endmodule
